// File: rtl/spot_sensor_scanner_if.sv
// Sensor-matrix scan bus: enable and raw row lines in, column drive and debounced occupancy out.
interface spot_sensor_scanner_if;
   logic       enable;
   logic [3:0] row_sense;
   logic [1:0] column_drive;
   logic [7:0] spots_occupied;
   logic [3:0] free_count;
   logic       spots_changed;
   logic       scan_done;

   // Controller / pin side: drives enable and row lines, observes the scanner outputs
   modport master (
      output enable, row_sense,
      input  column_drive, spots_occupied, free_count, spots_changed, scan_done
   );

   // Scanner side
   modport slave (
      input  enable, row_sense,
      output column_drive, spots_occupied, free_count, spots_changed, scan_done
   );
endinterface

// File: rtl/spot_sensor_scanner.sv
// 2x4 parking-spot sensor matrix scanner.
// Drives one column low at a time, samples the four active-low row lines on the last
// dwell cycle, and debounces every spot before it is published on spots_occupied.
module spot_sensor_scanner #(
   parameter int unsigned TickMax       = 166666,
   parameter int unsigned DebounceCount = 4
) (
   input logic                  clk_i,
   input logic                  rst_ni,
   spot_sensor_scanner_if.slave sns
);

   localparam int unsigned CntW = (TickMax > 1) ? $clog2(TickMax) : 1;
   localparam logic [CntW-1:0] TickLast = CntW'(TickMax - 1);
   localparam logic [3:0]      DbLast   = 4'(DebounceCount - 1);

   typedef enum logic [1:0] {IDLE, COL0, COL1, UPDATE} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] tick_q, tick_d;
   logic [3:0]      sync1_q, sync2_q;
   logic [7:0]      raw_q, raw_d;
   logic [7:0][3:0] cnt_q, cnt_d;
   logic [7:0]      occ_q, occ_d;
   logic [3:0]      free_q, free_d;
   logic [1:0]      col_q, col_d;
   logic            changed_q, changed_d;
   logic            done_q, done_d;
   logic [3:0]      pop;

   // State and output registers, including the row-line synchronizer
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         tick_q    <= '0;
         sync1_q   <= '0;
         sync2_q   <= '0;
         raw_q     <= '0;
         cnt_q     <= '0;
         occ_q     <= '0;
         free_q    <= 4'd8;
         col_q     <= 2'b11;
         changed_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         tick_q    <= tick_d;
         sync1_q   <= sns.row_sense;
         sync2_q   <= sync1_q;
         raw_q     <= raw_d;
         cnt_q     <= cnt_d;
         occ_q     <= occ_d;
         free_q    <= free_d;
         col_q     <= col_d;
         changed_q <= changed_d;
         done_q    <= done_d;
      end
   end

   // Scan sequencing, sampling, debounce step and registered-output next values
   always_comb begin
      state_d   = state_q;
      tick_d    = tick_q;
      raw_d     = raw_q;
      cnt_d     = cnt_q;
      occ_d     = occ_q;
      changed_d = 1'b0;
      done_d    = 1'b0;
      col_d     = 2'b11;
      pop       = 4'd0;

      case (state_q)
         IDLE: begin
            tick_d = '0;
            if (sns.enable) state_d = COL0;
         end
         COL0: begin
            if (tick_q == TickLast) begin
               raw_d[3:0] = ~sync2_q;
               tick_d     = '0;
               state_d    = COL1;
            end else begin
               tick_d = tick_q + CntW'(1);
            end
         end
         COL1: begin
            if (tick_q == TickLast) begin
               raw_d[7:4] = ~sync2_q;
               tick_d     = '0;
               state_d    = UPDATE;
            end else begin
               tick_d = tick_q + CntW'(1);
            end
         end
         UPDATE: begin
            tick_d = '0;
            for (int i = 0; i < 8; i++) begin
               if (raw_q[i] == occ_q[i]) begin
                  cnt_d[i] = 4'd0;
               end else if (cnt_q[i] == DbLast) begin
                  occ_d[i] = raw_q[i];
                  cnt_d[i] = 4'd0;
               end else begin
                  cnt_d[i] = cnt_q[i] + 4'd1;
               end
            end
            done_d    = 1'b1;
            changed_d = (occ_d != occ_q);
            state_d   = COL0;
         end
         default: state_d = IDLE;
      endcase

      // Dropping enable abandons any partial scan; debounce state is untouched
      if (!sns.enable) begin
         state_d = IDLE;
         tick_d  = '0;
      end

      for (int i = 0; i < 8; i++) pop = pop + 4'(occ_d[i]);
      free_d = 4'd8 - pop;

      // Column drive follows the next state so it is registered and aligned with it
      case (state_d)
         COL0:    col_d = 2'b10;
         COL1:    col_d = 2'b01;
         default: col_d = 2'b11;
      endcase
   end

   assign sns.column_drive   = col_q;
   assign sns.spots_occupied = occ_q;
   assign sns.free_count     = free_q;
   assign sns.spots_changed  = changed_q;
   assign sns.scan_done      = done_q;

endmodule

// File: tb/tb_spot_sensor_scanner.sv
// Directed bench for spot_sensor_scanner with TickMax=4, DebounceCount=2.
// A small matrix model turns the physical occupancy vector into row lines for the driven column.
module tb_spot_sensor_scanner;

   logic clk;
   logic rst_n;
   logic [7:0] phys;
   int checks;
   int failures;

   spot_sensor_scanner_if sif ();

   spot_sensor_scanner #(.TickMax(4), .DebounceCount(2)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .sns    (sif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Matrix model: an occupied spot pulls its row low only while its column is driven
   assign sif.row_sense = (sif.column_drive == 2'b10) ? ~phys[3:0] :
                          (sif.column_drive == 2'b01) ? ~phys[7:4] : 4'hF;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Checks taken on the first COL0 cycle after an UPDATE
   task automatic chk_post(input string tag, input logic [7:0] occ, input logic [3:0] free,
                           input logic chg);
      chk({tag, "_occ"},  sif.spots_occupied, occ);
      chk({tag, "_free"}, 8'(sif.free_count), 8'(free));
      chk({tag, "_chg"},  8'(sif.spots_changed), 8'(chg));
      chk({tag, "_done"}, 8'(sif.scan_done), 8'd1);
   endtask

   initial begin
      logic [1:0] exp_col;
      logic       exp_done;
      int         idx;
      checks     = 0;
      failures   = 0;
      phys       = 8'h00;
      rst_n      = 1'b0;
      sif.enable = 1'b0;

      // Reset held for 3 cycles, released with enable low
      cyc(3);
      rst_n = 1'b1;
      chk("rst_col",  8'(sif.column_drive), 8'h03);
      chk("rst_occ",  sif.spots_occupied, 8'h00);
      chk("rst_free", 8'(sif.free_count), 8'd8);
      chk("rst_chg",  8'(sif.spots_changed), 8'd0);
      chk("rst_done", 8'(sif.scan_done), 8'd0);
      cyc(3);
      chk("idle_col",  8'(sif.column_drive), 8'h03);
      chk("idle_done", 8'(sif.scan_done), 8'd0);

      // Column timing: 4 x col0, 4 x col1, 1 x break, ScanDone on the cycle after the break
      sif.enable = 1'b1;
      for (int k = 1; k <= 18; k++) begin
         cyc(1);
         idx      = (k - 1) % 9;
         exp_col  = (idx < 4) ? 2'b10 : (idx < 8) ? 2'b01 : 2'b11;
         exp_done = (idx == 0) && (k > 1);
         chk($sformatf("tim_col_%0d", k),  8'(sif.column_drive), 8'(exp_col));
         chk($sformatf("tim_done_%0d", k), 8'(sif.scan_done), 8'(exp_done));
      end
      cyc(1);
      chk_post("scan2", 8'h00, 4'd8, 1'b0);

      // Debounce: spot 6 occupied, flips only after the second disagreeing scan
      phys = 8'h40;
      cyc(9);
      chk_post("db1", 8'h00, 4'd8, 1'b0);
      cyc(9);
      chk_post("db2", 8'h40, 4'd7, 1'b1);
      cyc(1);
      chk("db_chg_pulse",  8'(sif.spots_changed), 8'd0);
      chk("db_done_pulse", 8'(sif.scan_done), 8'd0);
      cyc(8);
      chk_post("db3", 8'h40, 4'd7, 1'b0);

      // Glitch rejection: spot 0 seen for one scan only
      phys = 8'h41;
      cyc(9);
      chk_post("gl1", 8'h40, 4'd7, 1'b0);
      phys = 8'h40;
      cyc(9);
      chk_post("gl2", 8'h40, 4'd7, 1'b0);

      // All spots occupied, then all released
      phys = 8'hFF;
      cyc(9);
      chk_post("full1", 8'h40, 4'd7, 1'b0);
      cyc(9);
      chk_post("full2", 8'hFF, 4'd0, 1'b1);
      phys = 8'h00;
      cyc(9);
      chk_post("empty1", 8'hFF, 4'd0, 1'b0);
      cyc(9);
      chk_post("empty2", 8'h00, 4'd8, 1'b1);

      // Enable dropped during col1: drive released, no ScanDone, outputs held
      cyc(5);
      chk("en_in_col1", 8'(sif.column_drive), 8'h01);
      sif.enable = 1'b0;
      cyc(1);
      chk("en_off_col", 8'(sif.column_drive), 8'h03);
      chk("en_off_occ", sif.spots_occupied, 8'h00);
      for (int k = 0; k < 8; k++) begin
         cyc(1);
         chk($sformatf("en_off_done_%0d", k), 8'(sif.scan_done), 8'd0);
         chk($sformatf("en_off_col_%0d", k), 8'(sif.column_drive), 8'h03);
      end
      chk("en_off_free", 8'(sif.free_count), 8'd8);

      // Re-enable restarts at col0; spot 1 gains one scan of debounce progress
      sif.enable = 1'b1;
      cyc(1);
      phys = 8'h02;
      chk("reen_col0", 8'(sif.column_drive), 8'h02);
      cyc(4);
      chk("reen_col1", 8'(sif.column_drive), 8'h01);
      cyc(5);
      chk_post("reen1", 8'h00, 4'd8, 1'b0);

      // Reset mid-scan discards debounce progress
      cyc(5);
      rst_n = 1'b0;
      cyc(3);
      chk("mrst_col",  8'(sif.column_drive), 8'h03);
      chk("mrst_occ",  sif.spots_occupied, 8'h00);
      chk("mrst_free", 8'(sif.free_count), 8'd8);
      chk("mrst_done", 8'(sif.scan_done), 8'd0);
      rst_n = 1'b1;
      cyc(1);
      chk("mrst_col0", 8'(sif.column_drive), 8'h02);
      cyc(9);
      chk_post("mrst1", 8'h00, 4'd8, 1'b0);
      cyc(9);
      chk_post("mrst2", 8'h02, 4'd7, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
